mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (loads and stores driven by MemRead/MemWrite/MemLen from the ID-stage decoder).
- Sequences each transaction with an FSM and handles byte-lane steering, load sign/zero extension and misalignment detection.
- Aborts transactions that exceed a bus timeout.
- Sits between the pipeline stage registers and the memory wrapper.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT, 16, maximum cycles m_req stays high awaiting m_ready before abort; must be ≥2.

Ports:
- clk  in  1  clock; all state on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held stable until if_valid
- if_addr  in  WIDTH  fetch byte address
- if_valid  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  WIDTH  fetched word
- if_err  out  1  fetch error (misaligned or timeout), valid with if_valid
- d_req  in  1  data request (MemRead|MemWrite); held stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_len  in  3  MemLen: 0 B, 1 H, 2 W, 3 BU, 4 HU; 5-7 illegal
- d_addr  in  WIDTH  data byte address
- d_wdata  in  WIDTH  store data, right-aligned
- d_valid  out  1  one-cycle pulse: d_rdata/d_err valid
- d_rdata  out  WIDTH  extended load result; 0 for stores and errors
- d_err  out  1  misaligned, illegal d_len or timeout
- m_req  out  1  memory request, held until m_ready or timeout
- m_we  out  1  memory write enable
- m_addr  out  WIDTH  word-aligned address {addr[31:2],2'b00}
- m_wdata  out  WIDTH  lane-replicated store data
- m_be  out  4  byte enables
- m_rdata  in  WIDTH  read word, valid when m_ready=1
- m_ready  in  1  one-cycle completion pulse; earliest in the first m_req cycle

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - Every output and internal register is 0, including the timeout counter.
  - An in-flight transaction is dropped with no response.
  - m_ready sampled outside IF_BUSY/D_BUSY is ignored.
- States: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE, grant (registered):
  - d_req has strict priority over if_req.
  - The granted request is checked first:
    - Legal: latch m_addr, m_we, m_wdata, m_be, the requester ID, d_len and addr[1:0]. Assert m_req next cycle. Go to D_BUSY or IF_BUSY.
    - Illegal: no m_req. Go directly to RESP with err=1.
  - Illegal conditions:
    - Fetch with if_addr[1:0]≠0.
    - H/HU with addr[0]=1.
    - W with addr[1:0]≠0.
    - d_len≥5.
- BUSY:
  - m_req=1 and the counter increments each cycle.
  - m_ready=1: capture m_rdata, go to RESP with err=0.
  - Counter reaches TIMEOUT-1 with no m_ready: go to RESP with err=1 and rdata 0. m_req is therefore high for exactly TIMEOUT cycles.
  - m_ready on the final cycle wins over timeout.
- RESP:
  - Lasts exactly one cycle, then IDLE. No grant is made in RESP, so a still-held request is not re-issued.
  - m_req=0.
  - Exactly one of if_valid/d_valid is high, matching the granted requester, with its err/rdata.
  - rdata outputs hold their value until the next RESP.
- Latency: request seen in IDLE at cycle 0 → m_req cycle 1 → m_ready at cycle k≥1 → valid at cycle k+1. Zero-wait memory gives a 3-cycle transaction period.
- Stores:
  - B: m_be = 4'b0001<<addr[1:0]; m_wdata = {4{wdata[7:0]}}.
  - H: m_be = 4'b0011<<{addr[1],1'b0}; m_wdata = {2{wdata[15:0]}}.
  - W: m_be = 4'b1111; m_wdata = wdata.
- Loads:
  - m_be follows the same lane rule, m_we=0.
  - Result is extracted from m_rdata>>(8*addr[1:0]).
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes the word through.
- Fetches: m_be = 4'b1111, m_we=0.
- Simultaneous if_req and d_req in IDLE: data is served, then fetch on the next IDLE.

Test Plan:
- Fetch, zero-wait: if_req=1, if_addr=0x100, m_ready in first m_req cycle with m_rdata=0x00500093 → m_addr=0x100, m_be=F, if_valid pulse at cycle 2 with if_rdata=0x00500093, if_err=0; no re-issue during RESP.
- Contention: if_req and d_req (LW 0x200) both rise in IDLE → data transaction first (m_addr=0x200); fetch m_req starts 2 cycles after d_valid.
- Store lanes: SB d_addr=0x203, d_wdata=0x000000AB → m_be=1000, m_wdata=0xABABABAB, m_we=1; SH d_addr=0x202, d_wdata=0x1234 → m_be=1100, m_wdata=0x12341234.
- Load extension: m_rdata=0x80F07F81 → LB @+3 gives 0xFFFFFF80; LBU @+1 gives 0x0000007F; LH @+2 gives 0xFFFF80F0; LHU @+0 gives 0x00007F81.
- Errors: LW d_addr=0x202 → no m_req, d_valid next-next cycle with d_err=1, d_rdata=0. d_len=6 → same. No m_ready for TIMEOUT=16 → m_req high exactly 16 cycles, then d_err=1. m_ready on cycle 16 → success.
- Reset mid-op: assert rst while in D_BUSY waiting → m_req drops immediately (async), all outputs 0; a late m_ready after release is ignored; next if_req is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store traffic. Data requests win over fetches. Each transaction is
// sequenced IDLE -> BUSY -> RESP, with lane steering, load extension,
// misalignment checks and a bus timeout.
//
// Handshake: a requester raises *_req and holds it with its operands stable
// until its *_valid pulses for one cycle. On the memory side m_req stays high
// until m_ready pulses or the timeout expires. m_ready counts only while m_req
// is high, and it may arrive in the first m_req cycle.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_len,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_valid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic             m_req,
    output logic             m_we,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic [3:0]       m_be,
    input  logic [WIDTH-1:0] m_rdata,
    input  logic             m_ready
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      len_q;
    logic [1:0]      lo_q;

    logic [WIDTH-1:0] g_addr;
    logic             g_ok;
    logic [3:0]       g_be;
    logic [WIDTH-1:0] g_wdata;

    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [WIDTH-1:0] ld_val;

    // Decode the request that would be granted: legality, lanes, store data
    always_comb begin
        g_addr  = d_req ? d_addr : if_addr;
        g_ok    = 1'b1;
        g_be    = 4'b1111;
        g_wdata = '0;
        if (d_req) begin
            case (d_len)
                3'd0, 3'd3: begin
                    g_be    = 4'b0001 << d_addr[1:0];
                    g_wdata = {4{d_wdata[7:0]}};
                end
                3'd1, 3'd4: begin
                    g_ok    = ~d_addr[0];
                    g_be    = 4'b0011 << {d_addr[1], 1'b0};
                    g_wdata = {2{d_wdata[15:0]}};
                end
                3'd2: begin
                    g_ok    = (d_addr[1:0] == 2'b00);
                    g_wdata = d_wdata;
                end
                default: g_ok = 1'b0;
            endcase
            if (!d_we) begin
                g_wdata = '0;
            end
        end else begin
            g_ok = (if_addr[1:0] == 2'b00);
        end
    end

    // Extract and extend the load result from the returned word
    always_comb begin
        case (lo_q)
            2'd0:    ld_b = m_rdata[7:0];
            2'd1:    ld_b = m_rdata[15:8];
            2'd2:    ld_b = m_rdata[23:16];
            default: ld_b = m_rdata[31:24];
        endcase
        ld_h = lo_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (len_q)
            3'd0:    ld_val = {{(WIDTH-8){ld_b[7]}}, ld_b};
            3'd3:    ld_val = {{(WIDTH-8){1'b0}}, ld_b};
            3'd1:    ld_val = {{(WIDTH-16){ld_h[15]}}, ld_h};
            3'd4:    ld_val = {{(WIDTH-16){1'b0}}, ld_h};
            3'd2:    ld_val = m_rdata;
            default: ld_val = '0;
        endcase
    end

    // Transaction FSM with registered memory-side and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            lo_q     <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            if_valid <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        cnt   <= '0;
                        len_q <= d_len;
                        lo_q  <= g_addr[1:0];
                        if (g_ok) begin
                            m_req   <= 1'b1;
                            m_we    <= d_req & d_we;
                            m_addr  <= {g_addr[WIDTH-1:2], 2'b00};
                            m_wdata <= g_wdata;
                            m_be    <= g_be;
                            state   <= d_req ? D_BUSY : IF_BUSY;
                        end else begin
                            // Illegal request: answer with an error, no bus cycle
                            state <= RESP;
                            if (d_req) begin
                                d_valid <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                if_valid <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end
                        end
                    end
                end
                IF_BUSY: begin
                    if (m_ready) begin
                        m_req    <= 1'b0;
                        if_valid <= 1'b1;
                        if_err   <= 1'b0;
                        if_rdata <= m_rdata;
                        state    <= RESP;
                    end else if (cnt == LAST) begin
                        m_req    <= 1'b0;
                        if_valid <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                D_BUSY: begin
                    if (m_ready) begin
                        m_req   <= 1'b0;
                        d_valid <= 1'b1;
                        d_err   <= 1'b0;
                        d_rdata <= m_we ? '0 : ld_val;
                        state   <= RESP;
                    end else if (cnt == LAST) begin
                        m_req   <= 1'b0;
                        d_valid <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // RESP: single response cycle, never grants
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions with a memory responder;
// responses are checked by a monitor against an expected queue.
module tb_mem_port_arbiter;

    localparam int W = 34;  // {is_data, err, rdata[31:0]}

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_len;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_ready;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && (if_valid || d_valid)) begin
            if (if_valid && d_valid) begin
                total++;
                bad++;
                $display("FAIL both_valid: if_valid and d_valid high together at %0t", $time);
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: if_valid=%b d_valid=%b with nothing expected at %0t",
                         if_valid, d_valid, $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_who",   {31'b0, d_valid}, {31'b0, e[33]});
                check("resp_err",   {31'b0, d_valid ? d_err : if_err}, {31'b0, e[32]});
                check("resp_rdata", d_valid ? d_rdata : if_rdata, e[31:0]);
            end
        end
    end

    // memory responder: answers in m_req cycle w+1 (w<0: never); returns
    // negedges until a valid (n), m_req cycles (mc), negedge of first m_req (fn)
    task automatic run(input int w, input logic [31:0] rd, input logic [31:0] ea,
                       input logic [3:0] ebe, input logic ewe, input logic [31:0] ewd,
                       output int n, output int mc, output int fn);
        bit done;
        n = 0; mc = 0; fn = 0; done = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (m_req) begin
                mc++;
                if (mc == 1) begin
                    fn = n;
                    check("m_addr", m_addr, ea);
                    check("m_be", {28'b0, m_be}, {28'b0, ebe});
                    check("m_we", {31'b0, m_we}, {31'b0, ewe});
                    if (ewe) check("m_wdata", m_wdata, ewd);
                end
                if (mc - 1 == w) begin
                    m_ready = 1'b1;
                    m_rdata = rd;
                end
            end
            if (if_valid || d_valid) begin
                check("m_req_in_resp", {31'b0, m_req}, 32'd0);
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                m_ready = 1'b0;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: no response after %0d cycles, required one", n);
        end
    endtask

    // driver: one complete transaction with latency and m_req length checks
    task automatic do_txn(input logic isd, input logic we, input logic [2:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int w, input logic [31:0] rd, input logic legal,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic err, input logic [31:0] erd);
        int n, mc, fn;
        exp_q.push_back({isd, err, erd});
        @(posedge clk);
        #1;
        if (isd) begin
            d_req = 1'b1; d_we = we; d_len = len; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        run(w, rd, {addr[31:2], 2'b00}, ebe, isd & we, ewd, n, mc, fn);
        if (legal) begin
            check("first_m_req_cycle", fn, 2);
            check("m_req_cycles", mc, (w < 0) ? 16 : w + 1);
            check("latency", n, (w < 0) ? 18 : w + 3);
        end else begin
            check("err_m_req_cycles", mc, 0);
            check("err_latency", n, 2);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0; if_req = 1'b0; m_ready = 1'b0;
    endtask

    initial begin
        int n, mc, fn;
        rst = 1'b1;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_len = '0;
        d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_be", {28'b0, m_be}, 32'd0);
        check("rst_valids", {30'b0, if_valid, d_valid}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);

        // fetch, zero wait
        do_txn(0, 0, 3'd0, 32'h100, 0, 0, 32'h00500093, 1, 4'hF, 0, 0, 32'h00500093);
        // fetch with wait states
        do_txn(0, 0, 3'd0, 32'h104, 0, 2, 32'h00A00113, 1, 4'hF, 0, 0, 32'h00A00113);

        // contention: data first, fetch m_req two cycles after d_valid
        exp_q.push_back({1'b1, 1'b0, 32'h11223344});
        exp_q.push_back({1'b0, 1'b0, 32'h00000013});
        @(posedge clk);
        #1;
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 0; d_len = 3'd2; d_addr = 32'h200;
        run(0, 32'h11223344, 32'h200, 4'hF, 0, 0, n, mc, fn);
        check("cont_data_latency", n, 3);
        @(posedge clk);
        #1;
        d_req = 0;
        run(0, 32'h00000013, 32'h100, 4'hF, 0, 0, n, mc, fn);
        check("cont_fetch_gap", fn, 2);
        check("cont_fetch_latency", n, 3);
        @(posedge clk);
        #1;
        if_req = 0;

        // stores: read data is ignored and d_rdata is 0
        do_txn(1, 1, 3'd0, 32'h203, 32'h000000AB, 0, 32'hFFFFFFFF, 1, 4'b1000, 32'hABABABAB, 0, 0);
        do_txn(1, 1, 3'd1, 32'h202, 32'h00001234, 1, 32'hFFFFFFFF, 1, 4'b1100, 32'h12341234, 0, 0);
        do_txn(1, 1, 3'd2, 32'h204, 32'hDEADBEEF, 2, 32'hFFFFFFFF, 1, 4'b1111, 32'hDEADBEEF, 0, 0);

        // load extension from 0x80F07F81
        do_txn(1, 0, 3'd0, 32'h303, 0, 0, 32'h80F07F81, 1, 4'b1000, 0, 0, 32'hFFFFFF80);
        do_txn(1, 0, 3'd3, 32'h301, 0, 1, 32'h80F07F81, 1, 4'b0010, 0, 0, 32'h0000007F);
        do_txn(1, 0, 3'd1, 32'h302, 0, 3, 32'h80F07F81, 1, 4'b1100, 0, 0, 32'hFFFF80F0);
        do_txn(1, 0, 3'd4, 32'h300, 0, 0, 32'h80F07F81, 1, 4'b0011, 0, 0, 32'h00007F81);
        do_txn(1, 0, 3'd2, 32'h308, 0, 0, 32'h80F07F81, 1, 4'b1111, 0, 0, 32'h80F07F81);

        // illegal requests
        do_txn(1, 0, 3'd2, 32'h202, 0, 0, 0, 0, 0, 0, 1, 0);
        do_txn(1, 0, 3'd6, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0);
        do_txn(1, 1, 3'd1, 32'h201, 32'h55, 0, 0, 0, 0, 0, 1, 0);
        do_txn(0, 0, 3'd0, 32'h102, 0, 0, 0, 0, 0, 0, 1, 0);

        // timeout, then m_ready on the final cycle
        do_txn(1, 0, 3'd2, 32'h208, 0, -1, 0, 1, 4'hF, 0, 1, 0);
        do_txn(1, 0, 3'd2, 32'h20C, 0, 15, 32'h12345678, 1, 4'hF, 0, 0, 32'h12345678);
        do_txn(0, 0, 3'd0, 32'h110, 0, -1, 0, 1, 4'hF, 0, 1, 0);

        // reset while a load waits on memory
        @(posedge clk);
        #1;
        d_req = 1; d_we = 0; d_len = 3'd2; d_addr = 32'h400;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req && n < 10);
        check("rst_mid_m_req_seen", {31'b0, m_req}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_m_req", {31'b0, m_req}, 32'd0);
        check("rst_mid_m_addr", m_addr, 32'd0);
        check("rst_mid_m_be_we", {27'b0, m_be, m_we}, 32'd0);
        check("rst_mid_valids", {30'b0, if_valid, d_valid}, 32'd0);
        d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_ready_m_req", {31'b0, m_req}, 32'd0);
        end
        do_txn(0, 0, 3'd0, 32'h104, 0, 0, 32'h00000013, 1, 4'hF, 0, 0, 32'h00000013);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
